// File: rtl/uart_rx_word.sv
// uart_rx_word
//   Serial receiver for 32-bit words. It recovers frames from a UART line
//   with this format: start bit (0), 32 data bits LSB first, stop bit (1).
//   Each bit lasts CLKS_PER_BIT clocks. A good frame is delivered as one word
//   with a one-cycle valid strobe. A bad stop bit is reported with a
//   one-cycle error strobe, and that word is discarded.
//
// Parameters
//   CLKS_PER_BIT  clocks per bit (4..512)
//   CNT_W         clock-counter width, must hold CLKS_PER_BIT-1
//
// Ports
//   i_Clock      in   1   system clock, rising edge
//   i_Reset      in   1   synchronous active-high reset
//   i_Rx_Serial  in   1   asynchronous serial line, idles high
//   o_Rx_DV      out  1   one-cycle strobe, o_Rx_Word holds a new good word
//   o_Rx_Word    out  32  last good word, held until the next good word
//   o_Rx_Active  out  1   high from start-bit detect until return to idle
//   o_Frame_Err  out  1   one-cycle strobe, stop bit sampled low
module uart_rx_word #(
    parameter int CLKS_PER_BIT = 87,
    parameter int CNT_W        = 9
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic        i_Rx_Serial,
    output logic        o_Rx_DV,
    output logic [31:0] o_Rx_Word,
    output logic        o_Rx_Active,
    output logic        o_Frame_Err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_CLEANUP
    } state_t;

    // The start bit is rechecked at its middle. After that, each full bit
    // period lands on the middle of the next bit.
    localparam logic [CNT_W-1:0] HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic              rx_meta;
    logic              rx_sync;
    state_t            state,      state_next;
    logic [CNT_W-1:0]  cnt,        cnt_next;
    logic [4:0]        idx,        idx_next;
    logic [31:0]       shift,      shift_next;
    logic [31:0]       word_next;
    logic              dv_next;
    logic              ferr_next;
    logic              active_next;

    // The synchroniser resets to 1 (idle line). Without that, the receiver
    // would see a false start bit as it leaves reset.
    // NOTE: sequential state uses non-blocking (<=) assignments, so every
    // flop samples the values from before the edge. Blocking assignments
    // here would create order-dependent races between the two flops.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= i_Rx_Serial;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            idx         <= '0;
            shift       <= '0;
            o_Rx_Word   <= '0;
            o_Rx_DV     <= 1'b0;
            o_Frame_Err <= 1'b0;
            o_Rx_Active <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            idx         <= idx_next;
            shift       <= shift_next;
            o_Rx_Word   <= word_next;
            o_Rx_DV     <= dv_next;
            o_Frame_Err <= ferr_next;
            o_Rx_Active <= active_next;
        end
    end

    // NOTE: every signal assigned in this block gets a default value first.
    // Any path that left a signal unassigned would infer a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = idx;
        shift_next = shift;
        word_next  = o_Rx_Word;
        dv_next    = 1'b0;
        ferr_next  = 1'b0;

        unique case (state)
            S_IDLE: begin
                cnt_next = '0;
                idx_next = '0;
                if (!rx_sync) state_next = S_START;
            end

            S_START: begin
                if (cnt == HALF) begin
                    cnt_next   = '0;
                    // A line that is high again at mid-start is a glitch.
                    state_next = rx_sync ? S_IDLE : S_DATA;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end

            S_DATA: begin
                if (cnt == LAST) begin
                    cnt_next        = '0;
                    shift_next[idx] = rx_sync;
                    if (idx == 5'd31) begin
                        idx_next   = '0;
                        state_next = S_STOP;
                    end else begin
                        idx_next = idx + 1'b1;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end

            S_STOP: begin
                if (cnt == LAST) begin
                    cnt_next = '0;
                    if (rx_sync) begin
                        word_next = shift;
                        dv_next   = 1'b1;
                    end else begin
                        ferr_next = 1'b1;
                    end
                    state_next = S_CLEANUP;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end

            // Wait here while the line is low (break or held-low line). This
            // keeps a broken stop bit from being seen as a new start bit.
            S_CLEANUP: begin
                cnt_next = '0;
                if (rx_sync) state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
                idx_next   = '0;
            end
        endcase

        active_next = (state_next != S_IDLE);
    end

endmodule

// File: tb/tb_uart_rx_word.sv
// tb_uart_rx_word
//   Directed bench for uart_rx_word with CLKS_PER_BIT=8 (H=3). A serial BFM
//   drives the line. A negedge monitor counts strobes and records words.
module tb_uart_rx_word;

    localparam int C = 8;

    logic        i_Clock;
    logic        i_Reset;
    logic        i_Rx_Serial;
    logic        o_Rx_DV;
    logic [31:0] o_Rx_Word;
    logic        o_Rx_Active;
    logic        o_Frame_Err;

    uart_rx_word #(.CLKS_PER_BIT(C), .CNT_W(9)) dut (
        .i_Clock    (i_Clock),
        .i_Reset    (i_Reset),
        .i_Rx_Serial(i_Rx_Serial),
        .o_Rx_DV    (o_Rx_DV),
        .o_Rx_Word  (o_Rx_Word),
        .o_Rx_Active(o_Rx_Active),
        .o_Frame_Err(o_Frame_Err)
    );

    initial i_Clock = 1'b0;
    always #5 i_Clock = ~i_Clock;

    // Monitor: sampled on the falling edge, away from the DUT's active edge.
    int          cyc         = 0;
    int          dv_cnt      = 0;
    int          fe_cnt      = 0;
    int          act_cnt     = 0;
    int          last_dv_cyc = 0;
    logic [31:0] last_word   = '0;
    logic [31:0] prev_word   = '0;

    always @(posedge i_Clock) cyc <= cyc + 1;

    always @(negedge i_Clock) begin
        if (o_Rx_DV) begin
            dv_cnt      <= dv_cnt + 1;
            prev_word   <= last_word;
            last_word   <= o_Rx_Word;
            last_dv_cyc <= cyc;
        end
        if (o_Frame_Err) fe_cnt  <= fe_cnt + 1;
        if (o_Rx_Active) act_cnt <= act_cnt + 1;
    end

    int n_checks = 0;
    int n_errors = 0;
    int start_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        i_Rx_Serial = b;
        repeat (C) @(negedge i_Clock);
    endtask

    task automatic send_frame(input logic [31:0] w, input logic stop_bit);
        start_cyc = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 32; i++) send_bit(w[i]);
        send_bit(stop_bit);
    endtask

    task automatic idle(input int n);
        i_Rx_Serial = 1'b1;
        repeat (n) @(negedge i_Clock);
    endtask

    typedef struct {
        logic [31:0] word;
        logic        stop_bit;
        int          exp_dv;
        int          exp_fe;
        logic [31:0] exp_word;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int dv0, fe0, act0;

        vecs[0] = '{32'hA5C30F81, 1'b1, 1, 0, 32'hA5C30F81};
        vecs[1] = '{32'h00000001, 1'b1, 1, 0, 32'h00000001};
        vecs[2] = '{32'h80000000, 1'b1, 1, 0, 32'h80000000};
        vecs[3] = '{32'h5555AAAA, 1'b1, 1, 0, 32'h5555AAAA};
        vecs[4] = '{32'h11111111, 1'b0, 0, 1, 32'h5555AAAA};

        // Reset state
        i_Reset     = 1'b1;
        i_Rx_Serial = 1'b1;
        repeat (3) @(negedge i_Clock);
        check("reset_dv",     {31'd0, o_Rx_DV},     32'd0);
        check("reset_word",   o_Rx_Word,            32'd0);
        check("reset_active", {31'd0, o_Rx_Active}, 32'd0);
        check("reset_ferr",   {31'd0, o_Frame_Err}, 32'd0);
        i_Reset = 1'b0;
        idle(16);

        // Table-driven frames
        for (int v = 0; v < 5; v++) begin
            dv0 = dv_cnt;
            fe0 = fe_cnt;
            send_frame(vecs[v].word, vecs[v].stop_bit);
            idle(2 * C);
            check($sformatf("vec%0d_dv", v),     32'(dv_cnt - dv0),    32'(vecs[v].exp_dv));
            check($sformatf("vec%0d_ferr", v),   32'(fe_cnt - fe0),    32'(vecs[v].exp_fe));
            check($sformatf("vec%0d_word", v),   o_Rx_Word,            vecs[v].exp_word);
            check($sformatf("vec%0d_active", v), {31'd0, o_Rx_Active}, 32'd0);
        end

        // Glitch: line low for 2 clocks, then high
        dv0 = dv_cnt; fe0 = fe_cnt; act0 = act_cnt;
        i_Rx_Serial = 1'b0;
        repeat (2) @(negedge i_Clock);
        idle(20);
        check("glitch_active_cycles", 32'(act_cnt - act0), 32'd4);
        check("glitch_active_now",    {31'd0, o_Rx_Active}, 32'd0);
        check("glitch_dv",            32'(dv_cnt - dv0), 32'd0);
        check("glitch_ferr",          32'(fe_cnt - fe0), 32'd0);
        check("glitch_word",          o_Rx_Word, 32'h5555AAAA);

        // Bad stop bit, then line held low for 40 bit times
        dv0 = dv_cnt; fe0 = fe_cnt;
        send_frame(32'hCAFEF00D, 1'b0);
        repeat (40 * C) @(negedge i_Clock);
        check("break_ferr",   32'(fe_cnt - fe0), 32'd1);
        check("break_dv",     32'(dv_cnt - dv0), 32'd0);
        check("break_word",   o_Rx_Word, 32'h5555AAAA);
        check("break_active", {31'd0, o_Rx_Active}, 32'd1);
        idle(4);
        check("break_release", {31'd0, o_Rx_Active}, 32'd0);
        dv0 = dv_cnt;
        send_frame(32'h12345678, 1'b1);
        idle(2 * C);
        check("after_break_dv",   32'(dv_cnt - dv0), 32'd1);
        check("after_break_word", o_Rx_Word, 32'h12345678);

        // Back-to-back frames with no idle gap
        dv0 = dv_cnt; fe0 = fe_cnt;
        send_frame(32'hFFFFFFFF, 1'b1);
        send_frame(32'h00000000, 1'b1);
        idle(2 * C);
        check("b2b_dv",    32'(dv_cnt - dv0), 32'd2);
        check("b2b_ferr",  32'(fe_cnt - fe0), 32'd0);
        check("b2b_first", prev_word, 32'hFFFFFFFF);
        check("b2b_second", last_word, 32'h00000000);

        // Latency and strobe width
        dv0 = dv_cnt;
        send_frame(32'h0F0F1234, 1'b1);
        idle(2 * C);
        check("latency_cycles", 32'(last_dv_cyc - start_cyc), 32'd271);
        check("latency_dv_width", 32'(dv_cnt - dv0), 32'd1);
        check("latency_word", o_Rx_Word, 32'h0F0F1234);

        // Reset in the middle of data bit 10
        dv0 = dv_cnt; fe0 = fe_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 10; i++) send_bit(1'(32'hDEADBEEF >> i));
        i_Rx_Serial = 1'b0;
        repeat (C / 2) @(negedge i_Clock);
        i_Reset     = 1'b1;
        i_Rx_Serial = 1'b1;
        @(negedge i_Clock);
        check("midreset_dv",     {31'd0, o_Rx_DV},     32'd0);
        check("midreset_word",   o_Rx_Word,            32'd0);
        check("midreset_active", {31'd0, o_Rx_Active}, 32'd0);
        check("midreset_ferr",   {31'd0, o_Frame_Err}, 32'd0);
        i_Reset = 1'b0;
        idle(40);
        check("midreset_no_dv",   32'(dv_cnt - dv0), 32'd0);
        check("midreset_no_ferr", 32'(fe_cnt - fe0), 32'd0);
        send_frame(32'hDEADBEEF, 1'b1);
        idle(2 * C);
        check("post_reset_dv",   32'(dv_cnt - dv0), 32'd1);
        check("post_reset_word", o_Rx_Word, 32'hDEADBEEF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
